// File: rtl/soc_config_regs_slave.sv
// Tile configuration register slave on a Wishbone classic bus.
// Exposes build-time tile parameters, a free-running cycle counter,
// one byte-writable scratch register and the compute-tile ID list.
// Every access is answered by one ack or err pulse one cycle after it is
// accepted. A new request is accepted at most every second cycle.
module soc_config_regs_slave #(
  parameter int unsigned      TILEID         = 0,
  parameter int unsigned      NUMTILES       = 4,
  parameter int unsigned      NUMCTS         = 4,
  parameter int unsigned      CORES_PER_TILE = 1,
  parameter int unsigned      GMEM_SIZE      = 0,
  parameter int unsigned      GMEM_TILE      = 0,
  parameter int unsigned      LMEM_SIZE      = 32'h0800_0000,
  parameter logic [1023:0]    CTLIST         = '0,
  parameter logic [5:0]       FEATURES       = 6'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [15:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  localparam logic [31:0] VERSION         = 32'h0000_0001;
  localparam logic [31:0] TOTAL_NUM_CORES = 32'(NUMCTS * CORES_PER_TILE);
  localparam logic [13:0] SCRATCH_WORD    = 14'd11;
  localparam logic [13:0] NUM_REG_WORDS   = 14'd12;

  typedef enum logic {IDLE, RESP} state_t;

  state_t      state;
  logic [31:0] scratch;
  logic [31:0] cycles;

  logic        req_p0;
  logic [13:0] word_p0;
  logic [5:0]  ct_idx_p0;
  logic [31:0] rd_data_p0;
  logic        rd_err_p0;
  logic        scratch_wr_p0;
  logic        unused_adr_bits;

  assign req_p0          = wb_cyc_i & wb_stb_i;
  assign word_p0         = wb_adr_i[15:2];
  assign unused_adr_bits = ^wb_adr_i[1:0];

  // Address decode and read-data selection for the request on the bus now.
  always_comb begin
    rd_data_p0    = '0;
    rd_err_p0     = 1'b0;
    scratch_wr_p0 = 1'b0;
    ct_idx_p0     = wb_adr_i[7:2];
    if (wb_adr_i[15:8] == 8'h02) begin
      // Entries past the populated part of the list read as zero, not error.
      if (32'(ct_idx_p0) < NUMCTS) begin
        rd_data_p0 = {16'h0, CTLIST[{ct_idx_p0, 4'b0000} +: 16]};
      end
    end else if (word_p0 < NUM_REG_WORDS) begin
      case (word_p0[3:0])
        4'd0:    rd_data_p0 = VERSION;
        4'd1:    rd_data_p0 = 32'(TILEID);
        4'd2:    rd_data_p0 = 32'(NUMTILES);
        4'd3:    rd_data_p0 = 32'(NUMCTS);
        4'd4:    rd_data_p0 = 32'(CORES_PER_TILE);
        4'd5:    rd_data_p0 = 32'(GMEM_SIZE);
        4'd6:    rd_data_p0 = 32'(GMEM_TILE);
        4'd7:    rd_data_p0 = 32'(LMEM_SIZE);
        4'd8:    rd_data_p0 = TOTAL_NUM_CORES;
        4'd9:    rd_data_p0 = {26'h0, FEATURES};
        4'd10:   rd_data_p0 = cycles;
        4'd11:   rd_data_p0 = scratch;
        default: rd_data_p0 = '0;
      endcase
    end else begin
      rd_err_p0 = 1'b1;
    end
    // Only SCRATCH is writable; writes never return data.
    if (wb_we_i) begin
      rd_data_p0 = '0;
      if (word_p0 == SCRATCH_WORD) begin
        scratch_wr_p0 = 1'b1;
      end else begin
        rd_err_p0 = 1'b1;
      end
    end
    if (rd_err_p0) begin
      rd_data_p0 = '0;
    end
  end

  // Two-state handshake FSM: capture in IDLE, pulse the response in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_p0) begin
            state    <= RESP;
            wb_ack_o <= ~rd_err_p0;
            wb_err_o <= rd_err_p0;
            wb_dat_o <= rd_data_p0;
          end
        end
        RESP: begin
          // Read data is held until the next capture.
          state    <= IDLE;
          wb_ack_o <= 1'b0;
          wb_err_o <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          wb_ack_o <= 1'b0;
          wb_err_o <= 1'b0;
        end
      endcase
    end
  end

  // Byte-masked SCRATCH update, committed at the capture edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      scratch <= '0;
    end else if (state == IDLE && req_p0 && scratch_wr_p0) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) begin
          scratch[8*b +: 8] <= wb_dat_i[8*b +: 8];
        end
      end
    end
  end

  // Free-running cycle counter; wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycles <= '0;
    end else begin
      cycles <= cycles + 32'd1;
    end
  end

endmodule

// File: doc/soc_config_regs_slave.md
SOC_CONFIG_REGS_SLAVE -- requirements
Module: soc_config_regs_slave

Interface
REQ-001 SHALL have parameter TILEID, default 0, this tile's index.
REQ-002 SHALL have parameter NUMTILES, default 4, total tiles.
REQ-003 SHALL have parameter NUMCTS, default 4, number of compute tiles (1..64).
REQ-004 SHALL have parameter CORES_PER_TILE, default 1, cores per compute tile.
REQ-005 SHALL have parameter GMEM_SIZE, default 0, global memory bytes.
REQ-006 SHALL have parameter GMEM_TILE, default 0, tile hosting global memory.
REQ-007 SHALL have parameter LMEM_SIZE, default 32'h0800_0000, local memory bytes.
REQ-008 SHALL have parameter CTLIST, default all-zero 64x16-bit packed, compute-tile ID list, entry i at bits [16*i+15:16*i].
REQ-009 SHALL have parameter FEATURES, default 6'b0, bit0 ENABLE_DM, bit1 ENABLE_PGAS, bit2 NA_ENABLE_MPSIMPLE, bit3 NA_ENABLE_DMA, bit4 USE_DEBUG, bit5 NOC_ENABLE_VCHANNELS.
REQ-010 SHALL have port clk  input  1  sole clock, rising edge.
REQ-011 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-012 SHALL have ports wb_cyc_i, wb_stb_i, wb_we_i  input  1 each  Wishbone classic cycle, strobe, write-enable.
REQ-013 SHALL have port wb_adr_i  input  16  byte address; bits [1:0] ignored.
REQ-014 SHALL have port wb_dat_i  input  32  write data.
REQ-015 SHALL have port wb_sel_i  input  4  byte selects.
REQ-016 SHALL have port wb_dat_o  output  32  read data.
REQ-017 SHALL have ports wb_ack_o, wb_err_o  output  1 each  response strobes.

Function
REQ-018 Register map (read-only unless stated): 0x00 VERSION=32'h0000_0001; 0x04 TILEID; 0x08 NUMTILES; 0x0C NUMCTS; 0x10 CORES_PER_TILE; 0x14 GMEM_SIZE; 0x18 GMEM_TILE; 0x1C LMEM_SIZE; 0x20 TOTAL_NUM_CORES; 0x24 FEATURES zero-extended; 0x28 CYCLES; 0x2C SCRATCH (read/write).
REQ-019 SHALL compute TOTAL_NUM_CORES = NUMCTS*CORES_PER_TILE, truncated to 32 bits.
REQ-020 CTLIST window 0x200-0x2FC SHALL map entry i=(adr-0x200)>>2 to {16'h0, CTLIST[i]}; entries i>=NUMCTS SHALL read 32'h0 with ack.
REQ-021 FSM states IDLE and RESP; IDLE->RESP when wb_cyc_i & wb_stb_i sampled high; RESP->IDLE unconditionally after one cycle.
REQ-022 Request SHALL be captured at the IDLE->RESP edge; response (ack or err, never both) SHALL be high exactly during RESP, i.e. one cycle latency.
REQ-023 wb_dat_o SHALL be registered at capture and hold until next capture; value is 32'h0 for writes and errors.
REQ-024 No request SHALL be accepted in RESP; back-to-back requests are served every second cycle.
REQ-025 Error SHALL be signalled for unmapped addresses (0x30-0x1FC, >=0x300) and for writes to any address other than 0x2C.
REQ-026 SCRATCH write SHALL update only bytes with wb_sel_i set, at the capture edge; wb_sel_i=0 write SHALL ack without change.
REQ-027 CYCLES SHALL be a 32-bit free-running counter incremented every cycle, wrapping 32'hFFFF_FFFF->0; read returns value at capture edge.
REQ-028 If wb_cyc_i deasserts while in RESP, the response SHALL still be issued for that one cycle; no state retained.
REQ-029 Reads SHALL have no side effects.

Reset
REQ-030 During rst: FSM->IDLE, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, SCRATCH=0, CYCLES=0.
REQ-031 rst asserted while in RESP SHALL drop the response in the next cycle and discard any pending write commit not yet performed.
REQ-032 First request SHALL be accepted in the first cycle after rst deasserts.

Verification
REQ-033 NUMCTS=4, CORES_PER_TILE=2: read 0x20 -> ack one cycle after stb, wb_dat_o=8, err=0.
REQ-034 Write 0x2C data 32'hA5A5_1234 sel 4'b0011 after reset, read 0x2C -> 32'h0000_1234.
REQ-035 Write 0x04 or read 0x40 -> wb_err_o high one cycle, wb_ack_o low, wb_dat_o=0.
REQ-036 CTLIST entry1=16'h0003, NUMCTS=2: read 0x204 -> 32'h0000_0003; read 0x208 -> 32'h0 with ack.
REQ-037 Read 0x28 twice with stb held continuously -> acks in cycles 1 and 3, second value exceeds first by 2.
REQ-038 Assert rst in RESP cycle -> next cycle ack=0, dat=0, SCRATCH=0; request after release served normally.
